bcd_timer_counter: RTL and testbench

- Parametrised N-digit BCD time counter, successor to the fixed 4-digit up-counting clock.
- Adds run/pause control, up or down counting, preset load, and countdown expiry.
- Commands arrive as single-cycle pulses from the keyboard decode logic upstream.
- Digit outputs feed the 7-segment display multiplexer downstream.

---
 rtl/bcd_timer_pkg.sv | 19 +
 rtl/bcd_digit_cell.sv | 34 +++
 rtl/bcd_timer_counter.sv | 154 +++++++++++++++
 tb/tb_bcd_timer_counter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD timer counter: controller states,
// BCD digit width and the prescaler divide-ratio helper.
package bcd_timer_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Clock cycles per count step.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the timer chain. Steps when the global step enable and
// its carry/borrow input are both high; wraps at its own maximum (up) or
// at zero (down) and reports that through cout to the next digit.
module bcd_digit_cell
  import bcd_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BCD_W-1:0] max_val,
  input  logic             load_en,
  input  logic [BCD_W-1:0] load_val,
  input  logic             step_en,
  input  logic             dir_down,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  // Carry (up) or borrow (down) ripples only through digits sitting at their wrap point.
  assign cout = cin & (dir_down ? (q == '0) : (q == max_val));

  // Digit register: load/clear beats stepping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_val;
    end else if (step_en && cin) begin
      if (dir_down) q <= (q == '0) ? max_val : q - BCD_W'(1);
      else          q <= (q == max_val) ? '0 : q + BCD_W'(1);
    end
  end

endmodule

// File: rtl/bcd_timer_counter.sv
// N-digit BCD run/pause/up/down timer with preset load and countdown expiry.
// Optional lap display is built only when BCD_TIMER_LAP_EN is defined.
//
// Command pulses are single-cycle and level-free: whatever is high on a
// rising edge is acted on, priority clear > load > stop > start.
module bcd_timer_counter
  import bcd_timer_pkg::*;
#(
  parameter int          CLK_HZ     = 50000000,
  parameter int          TICK_HZ    = 1,
  parameter int          NUM_DIGITS = 4,
  parameter logic [31:0] DIGIT_MAX  = 32'h00009959
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_start,
  input  logic                        cmd_stop,
  input  logic                        cmd_clear,
  input  logic                        cmd_load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
  input  logic                        dir_down,
  input  logic                        cmd_lap,
  output logic [BCD_W*NUM_DIGITS-1:0] digits,
  output logic                        running,
  output logic                        tick,
  output logic                        wrapped,
  output logic                        expired,
  output logic                        blink
);

  localparam int W   = BCD_W * NUM_DIGITS;
  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  state_t              state, state_nx;
  logic [PW-1:0]       pre, pre_nx;
  logic [W-1:0]        live;
  logic [W-1:0]        load_sat;
  logic [NUM_DIGITS:0] chain;
  logic                step_en;
  logic                all_zero;
  logic                down_to_zero;
  logic                roll_up;

  assign tick     = (state == ST_RUN) && (pre == PRE_LAST);
  assign all_zero = (live == '0);
  // A down-step from zero would wrap; that case expires instead of stepping.
  assign step_en  = tick & ~cmd_clear & ~cmd_load & ~(dir_down & all_zero);
  // Only the value 1 steps down to all-zero.
  assign down_to_zero = step_en & dir_down & (live == W'(1));
  assign roll_up      = step_en & ~dir_down & chain[NUM_DIGITS];
  assign chain[0]     = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam logic [BCD_W-1:0] MAXV = DIGIT_MAX[BCD_W*i +: BCD_W];

    assign load_sat[BCD_W*i +: BCD_W] =
      (load_val[BCD_W*i +: BCD_W] > MAXV) ? MAXV : load_val[BCD_W*i +: BCD_W];

    bcd_digit_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .max_val  (MAXV),
      .load_en  (cmd_clear | cmd_load),
      .load_val (cmd_clear ? {BCD_W{1'b0}} : load_sat[BCD_W*i +: BCD_W]),
      .step_en  (step_en),
      .dir_down (dir_down),
      .cin      (chain[i]),
      .q        (live[BCD_W*i +: BCD_W]),
      .cout     (chain[i+1])
    );
  end

  // Controller next state.
  always_comb begin
    state_nx = state;
    if (cmd_clear) begin
      state_nx = ST_IDLE;
    end else if (cmd_load) begin
      if (state == ST_DONE) state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (cmd_start && !cmd_stop) state_nx = ST_RUN;
        ST_RUN: begin
          if (cmd_stop)                                  state_nx = ST_PAUSE;
          else if (dir_down && (all_zero || down_to_zero)) state_nx = ST_DONE;
        end
        ST_PAUSE: if (cmd_start && !cmd_stop) state_nx = ST_RUN;
        default:  state_nx = state;
      endcase
    end
  end

  // Prescaler next value: runs in RUN, frozen in PAUSE, parked at 0 otherwise.
  always_comb begin
    pre_nx = pre;
    if (cmd_clear || cmd_load) begin
      pre_nx = '0;
    end else begin
      case (state)
        ST_RUN:   pre_nx = (pre == PRE_LAST) ? '0 : pre + PW'(1);
        ST_PAUSE: pre_nx = pre;
        default:  pre_nx = '0;
      endcase
    end
  end

  // State, prescaler and the registered roll-over pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      pre     <= '0;
      wrapped <= 1'b0;
    end else begin
      state   <= state_nx;
      pre     <= pre_nx;
      wrapped <= roll_up;
    end
  end

  assign running = (state == ST_RUN);
  assign expired = (state == ST_DONE);
  assign blink   = digits[0];

`ifdef BCD_TIMER_LAP_EN
  logic         lap_on;
  logic [W-1:0] lap_val;

  // Lap toggle: freeze a snapshot for display while counting carries on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_on  <= 1'b0;
      lap_val <= '0;
    end else if (cmd_clear || cmd_load) begin
      lap_on <= 1'b0;
    end else if (cmd_lap && (state == ST_RUN || state == ST_PAUSE)) begin
      if (!lap_on) begin
        lap_on  <= 1'b1;
        lap_val <= live;
      end else begin
        lap_on <= 1'b0;
      end
    end
  end

  assign digits = lap_on ? lap_val : live;
`else
  logic unused_lap;
  assign unused_lap = cmd_lap;
  assign digits     = live;
`endif

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Bench for bcd_timer_counter (CLK_HZ=10, TICK_HZ=1, 4 digits, max 9959).
// The model holds the count as a single mixed-radix integer and derives
// digit fields from it; it is checked every cycle, and directed literal
// expectations pin both the model and the DUT.
module tb_bcd_timer_counter;

  localparam int          ND   = 4;
  localparam int          W    = 4 * ND;
  localparam int          DIV  = 10;
  localparam logic [31:0] DMAX = 32'h00009959;

  logic         clk;
  logic         rst;
  logic         cmd_start, cmd_stop, cmd_clear, cmd_load, cmd_lap, dir_down;
  logic [W-1:0] load_val;
  logic [W-1:0] digits;
  logic         running, tick, wrapped, expired, blink;

  int total = 0;
  int bad   = 0;

  bcd_timer_counter #(
    .CLK_HZ     (10),
    .TICK_HZ    (1),
    .NUM_DIGITS (ND),
    .DIGIT_MAX  (DMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .cmd_clear (cmd_clear),
    .cmd_load  (cmd_load),
    .load_val  (load_val),
    .dir_down  (dir_down),
    .cmd_lap   (cmd_lap),
    .digits    (digits),
    .running   (running),
    .tick      (tick),
    .wrapped   (wrapped),
    .expired   (expired),
    .blink     (blink)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Modes: 0 idle, 1 run, 2 pause, 3 done. The count is kept as a
  // mixed-radix integer in [0, 6000).
  int           m_mode;
  int           m_pre;
  int           m_pos;
  bit           m_wrap;
  bit           m_lap_on;
  logic [W-1:0] m_lap;

  function automatic int radix(input int i);
    return int'(DMAX[4*i +: 4]) + 1;
  endfunction

  function automatic int span();
    int s = 1;
    for (int i = 0; i < ND; i++) s *= radix(i);
    return s;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int p);
    logic [W-1:0] v = '0;
    int r = p;
    for (int i = 0; i < ND; i++) begin
      v[4*i +: 4] = 4'(r % radix(i));
      r = r / radix(i);
    end
    return v;
  endfunction

  function automatic int load_pos(input logic [W-1:0] lv);
    int p = 0;
    int f;
    for (int i = ND - 1; i >= 0; i--) begin
      f = int'(lv[4*i +: 4]);
      if (f > radix(i) - 1) f = radix(i) - 1;
      p = p * radix(i) + f;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pre = 0; m_pos = 0; m_wrap = 0; m_lap_on = 0; m_lap = '0;
  endtask

  task automatic model_compare();
    logic [W-1:0] disp;
    disp = m_lap_on ? m_lap : to_bcd(m_pos);
    chk("m_digits",  32'(digits),  32'(disp));
    chk("m_running", 32'(running), 32'(m_mode == 1));
    chk("m_tick",    32'(tick),    32'(m_mode == 1 && m_pre == DIV - 1));
    chk("m_wrapped", 32'(wrapped), 32'(m_wrap));
    chk("m_expired", 32'(expired), 32'(m_mode == 3));
    chk("m_blink",   32'(blink),   32'(disp[0]));
  endtask

  task automatic model_advance();
    int nxt_pre;
    m_wrap = 0;
    if (cmd_clear) begin
      m_pos = 0; m_pre = 0; m_mode = 0; m_lap_on = 0;
    end else if (cmd_load) begin
      m_pos = load_pos(load_val); m_pre = 0; m_lap_on = 0;
      if (m_mode == 3) m_mode = 0;
    end else begin
`ifdef BCD_TIMER_LAP_EN
      if (cmd_lap && (m_mode == 1 || m_mode == 2)) begin
        if (!m_lap_on) m_lap = to_bcd(m_pos);
        m_lap_on = !m_lap_on;
      end
`endif
      if (m_mode == 1 && m_pre == DIV - 1 && !(dir_down && m_pos == 0)) begin
        if (dir_down) m_pos = m_pos - 1;
        else begin
          if (m_pos == span() - 1) m_wrap = 1;
          m_pos = (m_pos + 1) % span();
        end
      end
      nxt_pre = (m_mode == 1) ? (m_pre + 1) % DIV : (m_mode == 2) ? m_pre : 0;
      case (m_mode)
        0, 2:    if (cmd_start && !cmd_stop) m_mode = 1;
        1: begin
          if (cmd_stop) m_mode = 2;
          else if (dir_down && m_pos == 0) m_mode = 3;
        end
        default: m_mode = m_mode;
      endcase
      m_pre = nxt_pre;
    end
  endtask

  // Single compare process: check the current cycle, then advance the model
  // with the inputs that the next rising edge will sample.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) model_reset();
      else begin
        model_compare();
        model_advance();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cmd_start = 0; cmd_stop = 0; cmd_clear = 0; cmd_load = 0; cmd_lap = 0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (tick !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk("tick_seen", 32'(tick), 32'd1);
  endtask

  task automatic run_ticks(input int k);
    int n;
    repeat (k) begin
      wait_tick(n);
      step();
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_val = v; cmd_load = 1; step();
  endtask

  task automatic do_clear();
    cmd_clear = 1; step();
  endtask

  task automatic do_start();
    cmd_start = 1; step();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 0; cmd_start = 0; cmd_stop = 0; cmd_clear = 0; cmd_load = 0;
    cmd_lap = 0; dir_down = 0; load_val = '0;
    #3;
    chk("rst_digits",  32'(digits),  32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_tick",    32'(tick),    32'h0);
    chk("rst_wrapped", 32'(wrapped), 32'h0);
    chk("rst_expired", 32'(expired), 32'h0);
    chk("rst_blink",   32'(blink),   32'h0);
    @(posedge clk); #1; rst = 1;
    step();

    // 600 ticks from zero, one tick every DIV clocks.
    do_start();
    for (int k = 0; k < 600; k++) begin
      wait_tick(n);
      chk("tick_gap", 32'(n), 32'd9);
      step();
    end
    chk("up600_digits", 32'(digits), 32'h1000);
    do_clear();
    chk("clear_digits", 32'(digits), 32'h0);

    // Full roll-over with wrapped pulse.
    do_load(16'h9959);
    do_start();
    wait_tick(n);
    step();
    chk("roll_digits", 32'(digits), 32'h0000);
    chk("roll_wrapped", 32'(wrapped), 32'd1);
    step();
    chk("roll_wrapped_end", 32'(wrapped), 32'd0);
    do_clear();

    // Saturating load of out-of-range fields.
    do_load(16'h9F7A);
    chk("load_sat", 32'(digits), 32'h9959);
    do_clear();

    // Carry and borrow across digit boundaries, direction change mid-run.
    do_load(16'h0059);
    do_start();
    run_ticks(1);
    chk("carry_digits", 32'(digits), 32'h0100);
    dir_down = 1;
    run_ticks(1);
    chk("borrow_digits", 32'(digits), 32'h0059);
    do_clear();

    // Countdown to expiry; start ignored in DONE; clear releases.
    do_load(16'h0003);
    do_start();
    run_ticks(3);
    chk("cd_digits", 32'(digits), 32'h0000);
    chk("cd_expired", 32'(expired), 32'd1);
    do_start();
    chk("done_start_expired", 32'(expired), 32'd1);
    chk("done_start_running", 32'(running), 32'd0);
    do_clear();
    chk("done_clear_expired", 32'(expired), 32'd0);

    // Start at zero while counting down: RUN for one cycle, then DONE.
    do_start();
    chk("zero_down_running", 32'(running), 32'd1);
    step();
    chk("zero_down_expired", 32'(expired), 32'd1);
    chk("zero_down_digits", 32'(digits), 32'h0);
    do_clear();
    dir_down = 0;

    // Pause keeps the partial interval.
    do_start();
    repeat (3) step();
    cmd_stop = 1; step();
    repeat (100) step();
    cmd_start = 1; step();
    n = 1;
    while (tick !== 1'b1 && n < 30) begin step(); n++; end
    chk("pause_restart_gap", 32'(n), 32'd6);
    step();
    chk("pause_digits", 32'(digits), 32'h0001);

    // Clear and start together.
    cmd_clear = 1; cmd_start = 1; step();
    chk("clr_start_running", 32'(running), 32'd0);
    chk("clr_start_digits", 32'(digits), 32'h0);

    // Stop and start together in RUN pauses with prescaler kept.
    do_start();
    repeat (4) step();
    cmd_start = 1; cmd_stop = 1; step();
    chk("stop_start_running", 32'(running), 32'd0);
    do_start();
    wait_tick(n);
    chk("stop_start_gap", 32'(n), 32'd4);
    step();
    do_clear();

    // Load in a tick cycle discards the step.
    do_load(16'h0005);
    do_start();
    wait_tick(n);
    load_val = 16'h0020; cmd_load = 1; step();
    chk("load_tick_digits", 32'(digits), 32'h0020);
    chk("load_tick_running", 32'(running), 32'd1);
    do_clear();

    // Lap display.
    do_load(16'h0012);
    do_start();
    cmd_lap = 1; step();
    run_ticks(5);
`ifdef BCD_TIMER_LAP_EN
    chk("lap_hold", 32'(digits), 32'h0012);
`else
    chk("lap_ignored", 32'(digits), 32'h0017);
`endif
    cmd_lap = 1; step();
    chk("lap_release", 32'(digits), 32'h0017);
    do_clear();

    // Asynchronous reset mid-run.
    do_start();
    run_ticks(1);
    step(); step();
    #2; rst = 0; #1;
    chk("arst_digits",  32'(digits),  32'h0);
    chk("arst_running", 32'(running), 32'h0);
    chk("arst_tick",    32'(tick),    32'h0);
    chk("arst_wrapped", 32'(wrapped), 32'h0);
    chk("arst_expired", 32'(expired), 32'h0);
    chk("arst_blink",   32'(blink),   32'h0);
    @(posedge clk); #1; rst = 1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
